// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one digit add/correct per clock, LSD first,
// with a start/busy/done handshake and a sticky flag for non-BCD operand digits.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESETN,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    input  logic                  cin,
    output logic [4*DIGITS-1:0]   sum_bcd,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res_sh;
    logic [CW-1:0]   cnt;
    logic            carry;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [4:0]      s;
    logic            carry_nxt;
    logic [3:0]      dig;
    logic [W-1:0]    res_nxt;
    logic            bad_dig;

    // Single-digit add/correct stage shared by every digit position.
    always_comb begin
        a_dig     = a_sh[3:0];
        b_dig     = b_sh[3:0];
        s         = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        carry_nxt = (s > 5'd9);
        dig       = carry_nxt ? 4'(s - 5'd10) : s[3:0];
        res_nxt   = {dig, res_sh[W-1:4]};
        bad_dig   = (a_dig > 4'd9) || (b_dig > 4'd9);
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the datapath registers are reset too, which keeps a
    // mid-operation abort fully deterministic.
    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            sum_bcd <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_sh  <= a_bcd;
                        b_sh  <= b_bcd;
                        carry <= cin;
                        cnt   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    res_sh <= res_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + 1'b1;
                    if (bad_dig) begin
                        err <= 1'b1;
                    end
                    // Last digit: publish the whole result in the same edge.
                    if (cnt == LAST) begin
                        sum_bcd <= res_nxt;
                        cout    <= carry_nxt;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: a 4-digit and a 2-digit instance driven
// with directed and random operands, checked against a digit-by-digit decimal model.
module tb_bcd_serial_add_ctrl;
    logic        CLOCK_50 = 1'b0;
    logic        RESETN;
    logic        start4, start2;
    logic [15:0] a4, b4;
    logic [7:0]  a2, b2;
    logic        cin4, cin2;
    logic [15:0] sum4;
    logic [7:0]  sum2;
    logic        cout4, busy4, done4, err4;
    logic        cout2, busy2, done2, err2;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_sum [2];
    logic        prev_cout [2];

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_serial_add_ctrl #(.DIGITS(4)) dut4 (
        .CLOCK_50(CLOCK_50), .RESETN(RESETN), .start(start4),
        .a_bcd(a4), .b_bcd(b4), .cin(cin4),
        .sum_bcd(sum4), .cout(cout4), .busy(busy4), .done(done4), .err(err4)
    );

    bcd_serial_add_ctrl #(.DIGITS(2)) dut2 (
        .CLOCK_50(CLOCK_50), .RESETN(RESETN), .start(start2),
        .a_bcd(a2), .b_bcd(b2), .cin(cin2),
        .sum_bcd(sum2), .cout(cout2), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Decimal addition digit by digit, straight from the add/correct rule.
    function automatic void model(input int n, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, output logic [31:0] s,
                                  output logic co, output logic e);
        int c = int'(ci);
        s = '0;
        e = 1'b0;
        for (int i = 0; i < n; i++) begin
            int ad = int'((a >> (4 * i)) & 32'hF);
            int bd = int'((b >> (4 * i)) & 32'hF);
            int t  = ad + bd + c;
            if (ad > 9 || bd > 9) e = 1'b1;
            if (t > 9) begin
                t = t - 10;
                c = 1;
            end else begin
                c = 0;
            end
            s = s | (32'(t & 15) << (4 * i));
        end
        co = (c != 0);
    endfunction

    function automatic logic [31:0] g_sum(input int n);
        return (n == 4) ? {16'b0, sum4} : {24'b0, sum2};
    endfunction
    function automatic logic [31:0] g_cout(input int n);
        return (n == 4) ? 32'(cout4) : 32'(cout2);
    endfunction
    function automatic logic [31:0] g_busy(input int n);
        return (n == 4) ? 32'(busy4) : 32'(busy2);
    endfunction
    function automatic logic [31:0] g_done(input int n);
        return (n == 4) ? 32'(done4) : 32'(done2);
    endfunction
    function automatic logic [31:0] g_err(input int n);
        return (n == 4) ? 32'(err4) : 32'(err2);
    endfunction

    task automatic drive(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic st);
        if (n == 4) begin
            a4 = a[15:0]; b4 = b[15:0]; cin4 = ci; start4 = st;
        end else begin
            a2 = a[7:0]; b2 = b[7:0]; cin2 = ci; start2 = st;
        end
    endtask

    // One full operation with cycle-accurate handshake and hold checks.
    task automatic op(input int n, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input string tag);
        logic [31:0] es;
        logic        ec, ee;
        int          p = (n == 4) ? 0 : 1;
        model(n, a, b, ci, es, ec, ee);
        drive(n, a, b, ci, 1'b1);
        tick();
        drive(n, ~a, ~b, ~ci, 1'b0);
        chk({tag, ".busy_k"}, g_busy(n), 32'd1);
        chk({tag, ".done_k"}, g_done(n), 32'd0);
        for (int i = 1; i < n; i++) begin
            tick();
            chk({tag, ".done_mid"}, g_done(n), 32'd0);
            chk({tag, ".sum_hold"}, g_sum(n), prev_sum[p]);
            chk({tag, ".cout_hold"}, g_cout(n), 32'(prev_cout[p]));
        end
        tick();
        chk({tag, ".done"}, g_done(n), 32'd1);
        chk({tag, ".busy_done"}, g_busy(n), 32'd1);
        chk({tag, ".sum"}, g_sum(n), es);
        chk({tag, ".cout"}, g_cout(n), 32'(ec));
        chk({tag, ".err"}, g_err(n), 32'(ee));
        tick();
        chk({tag, ".done_fall"}, g_done(n), 32'd0);
        chk({tag, ".busy_fall"}, g_busy(n), 32'd0);
        chk({tag, ".err_sticky"}, g_err(n), 32'(ee));
        prev_sum[p]  = es;
        prev_cout[p] = ec;
    endtask

    initial begin
        logic [31:0] ra, rb, es;
        logic        ec, ee;
        int          t1, t2;
        bit          seen;

        RESETN = 1'b0;
        drive(4, 0, 0, 1'b0, 1'b0);
        drive(2, 0, 0, 1'b0, 1'b0);
        prev_sum[0] = '0; prev_sum[1] = '0;
        prev_cout[0] = 1'b0; prev_cout[1] = 1'b0;
        tick();
        tick();
        chk("rst.sum", g_sum(4), 32'h0);
        chk("rst.cout", g_cout(4), 32'd0);
        chk("rst.busy", g_busy(4), 32'd0);
        chk("rst.done", g_done(4), 32'd0);
        chk("rst.err", g_err(4), 32'd0);
        chk("rst.sum2", g_sum(2), 32'h0);
        #2 RESETN = 1'b1;
        tick();

        op(4, 32'h1234, 32'h5678, 1'b0, "basic");
        op(4, 32'h9999, 32'h0001, 1'b0, "ripple");
        op(4, 32'h0000, 32'h0000, 1'b1, "cin_only");
        op(4, 32'h00A5, 32'h0003, 1'b0, "bad_digit");
        op(4, 32'h0042, 32'h0017, 1'b0, "err_clear");

        // start while busy is ignored and not queued
        drive(4, 32'h1111, 32'h2222, 1'b0, 1'b1);
        tick();
        drive(4, 0, 0, 1'b0, 1'b0);
        tick();
        drive(4, 32'h9999, 32'h9999, 1'b1, 1'b1);
        tick();
        drive(4, 0, 0, 1'b0, 1'b0);
        tick();
        chk("ign.done_early", g_done(4), 32'd0);
        tick();
        chk("ign.done", g_done(4), 32'd1);
        chk("ign.sum", g_sum(4), 32'h3333);
        chk("ign.cout", g_cout(4), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done4 === 1'b1) seen = 1'b1;
        end
        chk("ign.no_requeue", 32'(seen), 32'd0);
        prev_sum[0] = 32'h3333; prev_cout[0] = 1'b0;

        // start held high: one result every DIGITS+2 cycles
        drive(4, 32'h4321, 32'h0789, 1'b1, 1'b1);
        model(4, 32'h4321, 32'h0789, 1'b1, es, ec, ee);
        t1 = -1; t2 = -1;
        for (int i = 0; i < 30 && t2 < 0; i++) begin
            tick();
            if (done4 === 1'b1) begin
                if (t1 < 0) t1 = i; else t2 = i;
            end
        end
        chk("b2b.first_seen", 32'(t1 >= 0), 32'd1);
        chk("b2b.spacing", 32'(t2 - t1), 32'd6);
        chk("b2b.sum", g_sum(4), es);
        drive(4, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && busy4 !== 1'b0; i++) tick();
        chk("b2b.drain", g_busy(4), 32'd0);
        tick();
        prev_sum[0] = es; prev_cout[0] = ec;

        // asynchronous abort mid-operation
        drive(4, 32'h5555, 32'h5555, 1'b0, 1'b1);
        tick();
        drive(4, 0, 0, 1'b0, 1'b0);
        tick();
        #2 RESETN = 1'b0;
        #1;
        chk("abort.busy", g_busy(4), 32'd0);
        chk("abort.done", g_done(4), 32'd0);
        chk("abort.sum", g_sum(4), 32'h0);
        chk("abort.cout", g_cout(4), 32'd0);
        chk("abort.err", g_err(4), 32'd0);
        #3 RESETN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done4 === 1'b1) seen = 1'b1;
        end
        chk("abort.no_done", 32'(seen), 32'd0);
        prev_sum[0] = '0; prev_cout[0] = 1'b0;
        prev_sum[1] = '0; prev_cout[1] = 1'b0;
        op(4, 32'h0808, 32'h0202, 1'b0, "after_abort");

        op(2, 32'h99, 32'h99, 1'b1, "d2_max");
        op(2, 32'h05, 32'h04, 1'b0, "d2_small");

        // random operands, occasionally with non-BCD digits
        for (int k = 0; k < 24; k++) begin
            int n = (k % 3 == 2) ? 2 : 4;
            ra = '0; rb = '0;
            for (int d = 0; d < n; d++) begin
                ra = ra | (32'(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
                                                          : $urandom_range(0, 9)) << (4 * d));
                rb = rb | (32'(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
                                                          : $urandom_range(0, 9)) << (4 * d));
            end
            op(n, ra, rb, 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
